// File: rtl/tnn_neuron_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : tnn_neuron_seq_if
// Brief    : Vector-in / result-out handshake bundle for tnn_neuron_seq.
//            master = producer/consumer side, slave = neuron side.
// Revision : 1.0 - initial release
// ============================================================================
interface tnn_neuron_seq_if #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 2,
  parameter int ACC_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*IN_W-1:0]   in_data;
  logic [2*N_IN-1:0]      in_weight;
  logic [ACC_W-1:0]       in_thresh;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_class;
  logic [ACC_W-1:0]       out_score;

  modport master (
    output in_valid, in_data, in_weight, in_thresh, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );

  modport slave (
    input  in_valid, in_data, in_weight, in_thresh, out_ready,
    output in_ready, out_valid, out_class, out_score
  );
endinterface
`default_nettype wire

// File: rtl/tnn_neuron_seq.sv
`default_nettype none
// ============================================================================
// Module   : tnn_neuron_seq
// Brief    : Sequential ternary-weight neuron. Latches a feature vector,
//            accumulates LANES weighted inputs per cycle, then holds the
//            signed score and the (score > threshold) decision until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_neuron_seq #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 2,
  parameter int LANES = 1,
  parameter int ACC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tnn_neuron_seq_if.slave   bus
);

  localparam int     N_GRP   = N_IN / LANES;
  localparam int     GW      = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam longint MAX_MAG = longint'(N_IN) * ((longint'(1) << IN_W) - 1);
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;

  // Reject configurations that cannot be processed in whole groups or
  // whose accumulator could overflow.
  generate
    if (N_IN % LANES != 0) begin : g_bad_lanes
      $error("tnn_neuron_seq: N_IN must be a multiple of LANES");
    end
    if (ACC_MAX < MAX_MAG) begin : g_bad_acc_w
      $error("tnn_neuron_seq: ACC_W too narrow for N_IN*(2^IN_W-1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state;
  logic [N_IN*IN_W-1:0]     data_q;
  logic [2*N_IN-1:0]        weight_q;
  logic signed [ACC_W-1:0]  thresh_q;
  logic signed [ACC_W-1:0]  acc;
  logic [GW-1:0]            grp;

  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     out_class_q;
  logic [ACC_W-1:0]         out_score_q;

  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  group_sum;
  logic signed [ACC_W-1:0]  acc_next;

  // Weighted sum of the current LANES-wide group; codes 00/10 contribute 0.
  always_comb begin
    term      = '0;
    group_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      term = ACC_W'(data_q[(int'(grp) * LANES + l) * IN_W +: IN_W]);
      case (weight_q[2 * (int'(grp) * LANES + l) +: 2])
        2'b01:   group_sum = group_sum + term;
        2'b11:   group_sum = group_sum - term;
        default: group_sum = group_sum;
      endcase
    end
    acc_next = acc + group_sum;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_q      <= '0;
      weight_q    <= '0;
      thresh_q    <= '0;
      acc         <= '0;
      grp         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= 1'b0;
      out_score_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            weight_q   <= bus.in_weight;
            thresh_q   <= bus.in_thresh;
            acc        <= '0;
            grp        <= '0;
            in_ready_q <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (grp == GW'(N_GRP - 1)) begin
            // grp is left on the last group so it never indexes past N_IN.
            out_valid_q <= 1'b1;
            out_score_q <= acc_next;
            out_class_q <= (acc_next > thresh_q);
            state       <= DONE;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;

`ifndef SYNTHESIS
  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_score) && $stable(bus.out_class)));

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && bus.out_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tnn_neuron_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tnn_neuron_seq
// Brief    : Self-checking bench for tnn_neuron_seq (LANES=1 and LANES=3
//            instances) against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tnn_neuron_seq;
  localparam int N_IN  = 9;
  localparam int IN_W  = 2;
  localparam int ACC_W = 8;
  localparam int DW    = N_IN * IN_W;
  localparam int WW    = 2 * N_IN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  tnn_neuron_seq_if #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) bus1 ();
  tnn_neuron_seq_if #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) bus3 ();

  tnn_neuron_seq #(.N_IN(N_IN), .IN_W(IN_W), .LANES(1), .ACC_W(ACC_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  tnn_neuron_seq #(.N_IN(N_IN), .IN_W(IN_W), .LANES(3), .ACC_W(ACC_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: plain signed sum of value*weight over all inputs.
  function automatic int model_score(input logic [DW-1:0] d, input logic [WW-1:0] w);
    int s;
    int v;
    logic [1:0] c;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      v = int'(d[i*IN_W +: IN_W]);
      c = w[2*i +: 2];
      if (c == 2'b01) s = s + v;
      else if (c == 2'b11) s = s - v;
    end
    return s;
  endfunction

  function automatic logic model_class(input int score, input logic [ACC_W-1:0] th);
    return score > int'($signed(th));
  endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [DW-1:0] d,
                          input logic [WW-1:0] w, input logic [ACC_W-1:0] th);
    if (sel) begin
      bus3.in_valid = v; bus3.in_data = d; bus3.in_weight = w; bus3.in_thresh = th;
    end else begin
      bus1.in_valid = v; bus1.in_data = d; bus1.in_weight = w; bus1.in_thresh = th;
    end
  endtask

  task automatic set_ready(input bit sel, input logic r);
    if (sel) bus3.out_ready = r;
    else     bus1.out_ready = r;
  endtask

  // Offer one vector, then count edges from the accept edge to out_valid.
  task automatic send_vec(input bit sel, input logic [DW-1:0] d, input logic [WW-1:0] w,
                          input logic [ACC_W-1:0] th, output int lat,
                          output logic [ACC_W-1:0] sc, output logic cl);
    int n;
    n = 0;
    while (!(sel ? bus3.in_ready : bus1.in_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    drive_in(sel, 1'b1, d, w, th);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, DW'($urandom), WW'($urandom), ACC_W'($urandom));
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sel ? bus3.out_valid : bus1.out_valid) begin
        lat = k;
        break;
      end
    end
    sc = sel ? bus3.out_score : bus1.out_score;
    cl = sel ? bus3.out_class : bus1.out_class;
  endtask

  task automatic consume(input bit sel);
    set_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_ready(sel, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_during got=%b exp=1", bus1.in_ready); end
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_during got=%b exp=0", bus1.out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus1.in_ready); end
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus1.out_valid); end
    total++; if (bus1.out_score !== 8'h00) begin bad++; $display("FAIL reset_out_score got=%h exp=00", bus1.out_score); end
    total++; if (bus1.out_class !== 1'b0) begin bad++; $display("FAIL reset_out_class got=%b exp=0", bus1.out_class); end
    total++; if (bus3.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_l3 got=%b exp=1", bus3.in_ready); end
  endtask

  task automatic test_all_plus;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    d = '1;
    for (int i = 0; i < N_IN; i++) w[2*i +: 2] = 2'b01;
    th = '0;
    e = model_score(d, w);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (lat !== 9) begin bad++; $display("FAIL plus_latency got=%0d exp=9", lat); end
    total++; if (sc !== ACC_W'(e)) begin bad++; $display("FAIL plus_score got=%0d exp=%0d", $signed(sc), e); end
    total++; if (cl !== model_class(e, th)) begin bad++; $display("FAIL plus_class got=%b exp=%b", cl, model_class(e, th)); end
    consume(1'b0);
  endtask

  task automatic test_all_minus;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    d = '1;
    w = '1;
    e = model_score(d, w);
    th = ACC_W'(-28);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (sc !== ACC_W'(e)) begin bad++; $display("FAIL minus_score got=%0d exp=%0d", $signed(sc), e); end
    total++; if (cl !== model_class(e, th)) begin bad++; $display("FAIL minus_class_below got=%b exp=%b", cl, model_class(e, th)); end
    consume(1'b0);
    th = ACC_W'(-27);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (cl !== model_class(e, th)) begin bad++; $display("FAIL minus_class_tie got=%b exp=%b", cl, model_class(e, th)); end
    consume(1'b0);
  endtask

  task automatic test_mixed;
    int vals [N_IN];
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    vals = '{3, 3, 3, 0, 2, 1, 1, 2, 3};
    for (int i = 0; i < N_IN; i++) begin
      d[i*IN_W +: IN_W] = IN_W'(vals[i]);
      w[2*i +: 2] = (i == 3 || i == 7 || i == 8) ? 2'b01 : 2'b11;
    end
    th = '0;
    e = model_score(d, w);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (sc !== ACC_W'(e)) begin bad++; $display("FAIL mixed_score got=%0d exp=%0d", $signed(sc), e); end
    total++; if (cl !== model_class(e, th)) begin bad++; $display("FAIL mixed_class got=%b exp=%b", cl, model_class(e, th)); end
    consume(1'b0);
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    d = DW'($urandom); w = WW'($urandom); th = ACC_W'($urandom_range(0, 20));
    e = model_score(d, w);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (sc !== ACC_W'(e)) begin bad++; $display("FAIL bp_score got=%0d exp=%0d", $signed(sc), e); end
    // Offer a competing vector while the result is held; it must be ignored.
    drive_in(1'b0, 1'b1, ~d, ~w, ~th);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (bus1.out_score !== ACC_W'(e) || bus1.out_class !== model_class(e, th) || bus1.out_valid !== 1'b1)
        begin bad++; $display("FAIL bp_hold cyc=%0d got=%0d/%b/%b exp=%0d/%b/1", c, $signed(bus1.out_score), bus1.out_class, bus1.out_valid, e, model_class(e, th)); end
      total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus1.in_ready); end
    end
    drive_in(1'b0, 1'b0, '0, '0, '0);
    consume(1'b0);
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus1.out_valid); end
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus1.in_ready); end
    d = DW'($urandom); w = WW'($urandom); th = ACC_W'($urandom);
    e = model_score(d, w);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (lat !== 9 || sc !== ACC_W'(e) || cl !== model_class(e, th))
      begin bad++; $display("FAIL bp_next got=%0d/%0d/%b exp=9/%0d/%b", lat, $signed(sc), cl, e, model_class(e, th)); end
    consume(1'b0);
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e, stale;
    d = '1; w = '0; th = '0;
    for (int i = 0; i < N_IN; i++) w[2*i +: 2] = 2'b01;
    drive_in(1'b0, 1'b1, d, w, th);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus1.out_valid !== 1'b0 || bus1.out_score !== 8'h00 || bus1.out_class !== 1'b0)
      begin bad++; $display("FAIL midreset_outputs got=%b/%h/%b exp=0/00/0", bus1.out_valid, bus1.out_score, bus1.out_class); end
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b exp=1", bus1.in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus1.out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midreset_stale got=%0d exp=0", stale); end
    // Reset while a result is pending in DONE.
    d = DW'($urandom); w = WW'($urandom); th = ACC_W'($urandom);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus1.out_valid !== 1'b0 || bus1.out_score !== 8'h00)
      begin bad++; $display("FAIL donereset_outputs got=%b/%h exp=0/00", bus1.out_valid, bus1.out_score); end
    @(posedge clk); #1 rst_n = 1'b1;
    d = DW'($urandom); w = WW'($urandom); th = ACC_W'($urandom);
    e = model_score(d, w);
    send_vec(1'b0, d, w, th, lat, sc, cl);
    total++; if (lat !== 9 || sc !== ACC_W'(e) || cl !== model_class(e, th))
      begin bad++; $display("FAIL after_reset got=%0d/%0d/%b exp=9/%0d/%b", lat, $signed(sc), cl, e, model_class(e, th)); end
    consume(1'b0);
  endtask

  task automatic test_random;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    for (int t = 0; t < 40; t++) begin
      d = DW'($urandom); w = WW'($urandom);
      th = (t % 4 == 0) ? ACC_W'($urandom_range(0, 20) - 10) : ACC_W'($urandom);
      e = model_score(d, w);
      send_vec(1'b0, d, w, th, lat, sc, cl);
      total++; if (lat !== 9 || sc !== ACC_W'(e) || cl !== model_class(e, th))
        begin bad++; $display("FAIL random t=%0d got=%0d/%0d/%b exp=9/%0d/%b", t, lat, $signed(sc), cl, e, model_class(e, th)); end
      consume(1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lanes3;
    logic [DW-1:0] d; logic [WW-1:0] w; logic [ACC_W-1:0] th, sc; logic cl; int lat, e;
    d = DW'($urandom);
    for (int i = 0; i < N_IN; i++) w[2*i +: 2] = 2'b10;
    th = ACC_W'(-1);
    e = model_score(d, w);
    send_vec(1'b1, d, w, th, lat, sc, cl);
    total++; if (lat !== 3) begin bad++; $display("FAIL l3_latency got=%0d exp=3", lat); end
    total++; if (sc !== ACC_W'(e)) begin bad++; $display("FAIL l3_zero_score got=%0d exp=%0d", $signed(sc), e); end
    total++; if (cl !== model_class(e, th)) begin bad++; $display("FAIL l3_zero_class got=%b exp=%b", cl, model_class(e, th)); end
    consume(1'b1);
    for (int t = 0; t < 12; t++) begin
      d = DW'($urandom); w = WW'($urandom); th = ACC_W'($urandom_range(0, 30) - 15);
      e = model_score(d, w);
      send_vec(1'b1, d, w, th, lat, sc, cl);
      total++; if (lat !== 3 || sc !== ACC_W'(e) || cl !== model_class(e, th))
        begin bad++; $display("FAIL l3_random t=%0d got=%0d/%0d/%b exp=3/%0d/%b", t, lat, $signed(sc), cl, e, model_class(e, th)); end
      consume(1'b1);
    end
  endtask

  // Scenario sequencer.
  initial begin
    drive_in(1'b0, 1'b0, '0, '0, '0);
    drive_in(1'b1, 1'b0, '0, '0, '0);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);
    test_reset();
    test_all_plus();
    test_all_minus();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_lanes3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
